// File: rtl/mem_handle_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_handle_responder
// Brief    : Four-channel round-robin responder for the mem_handle req/done
//            protocol, backed by a word-addressed scratchpad.
// Revision : 1.0 - initial release
// ============================================================================
module mem_handle_responder #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          req,
    input  logic [3:0]          we,
    input  logic [4*ADDR_W-1:0] addr,
    input  logic [4*32-1:0]     wdata,
    output logic [3:0]          done,
    output logic [31:0]         rdata,
    output logic                busy,
    output logic                oob
);

    localparam int                 c_CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(RD_LAT - 1);
    localparam logic [ADDR_W:0]    c_DEPTH    = (ADDR_W+1)'(DEPTH);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_RESP   = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [1:0]         r_rr;
    logic [1:0]         w_gnt;
    logic [1:0]         r_gnt;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_done;
    logic [31:0]        r_rdata;
    logic               r_oob;
    logic               w_fire;
    logic               w_in_range;
    logic [31:0]        w_rd_word;

    logic [31:0] r_mem [DEPTH];

    assign w_fire     = (r_state == c_ACCESS) && (r_cnt == '0);
    assign w_in_range = ({1'b0, r_addr} < c_DEPTH);
    assign w_rd_word  = r_mem[r_addr];

    assign done  = r_done;
    assign rdata = r_rdata;
    assign busy  = (r_state != c_IDLE);
    assign oob   = r_oob;

    // First requesting channel at or above the rr pointer, wrapping 3 -> 0.
    always_comb begin
        w_gnt = r_rr;
        for (int k = 3; k >= 0; k--) begin
            if (req[r_rr + 2'(k)]) begin
                w_gnt = r_rr + 2'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (|req) w_state_nxt = c_ACCESS;
            c_ACCESS: if (r_cnt == '0) w_state_nxt = c_RESP;
            c_RESP:   w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr    <= 2'd0;
            r_gnt   <= 2'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_done  <= '0;
            r_rdata <= '0;
            r_oob   <= 1'b0;
        end else begin
            r_done <= '0;
            if ((r_state == c_IDLE) && (|req)) begin
                r_gnt   <= w_gnt;
                r_we    <= we[w_gnt];
                r_addr  <= addr[w_gnt*ADDR_W +: ADDR_W];
                r_wdata <= wdata[w_gnt*32 +: 32];
                r_cnt   <= c_CNT_INIT;
            end
            if (r_state == c_ACCESS) begin
                if (r_cnt == '0) begin
                    r_done <= 4'b0001 << r_gnt;
                    // Out-of-range reads return zero rather than aliased data.
                    if (!r_we) begin
                        r_rdata <= w_in_range ? w_rd_word : 32'h0;
                    end
                    if (!w_in_range) begin
                        r_oob <= 1'b1;
                    end
                end else begin
                    r_cnt <= r_cnt - c_CNT_W'(1);
                end
            end
            if (r_state == c_RESP) begin
                r_rr <= r_gnt + 2'd1;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_fire && r_we && w_in_range) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_handle_responder.md
Name: mem_handle_responder

Overview:
- Memory-side endpoint of the mem_handle request/done protocol that FPU units such as convolution forward/backward use as initiators.
- Arbitrates four requester channels (a, b, c, d) round-robin onto one internal word-addressed scratchpad.
- Performs the read or write for the granted channel and returns a one-cycle done pulse with read data.
- Sits between the FPU datapath blocks and on-chip storage.

Parameters:
- ADDR_W, 10, word address width.
- DEPTH, 1024, scratchpad depth in 32-bit words (≤ 2^ADDR_W).
- RD_LAT, 2, cycles from grant to read data valid (≥1); writes use the same latency.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  4  per-channel request valid; bit0=a, 1=b, 2=c, 3=d
- we  in  4  per-channel write enable (1=write, 0=read)
- addr  in  4*ADDR_W  per-channel word address, channel i at [i*ADDR_W +: ADDR_W]
- wdata  in  4*32  per-channel write data
- done  out  4  per-channel completion pulse
- rdata  out  32  read data, valid when any done bit is set for a read
- busy  out  1  high while a transaction is in flight
- oob  out  1  sticky flag; set on any access with addr ≥ DEPTH, cleared only by rst

Behaviour:
- Reset values: done=0, rdata=0, busy=0, oob=0, state=IDLE, rr pointer=0 (channel a highest priority), latency counter=0.
- Scratchpad contents are not reset.
- Initiator rule: assert req with stable we/addr/wdata and hold until its done pulse; deassert req in the cycle after done.
- The responder never samples a channel's inputs except in that channel's grant cycle.
- FSM states:
  - IDLE: if any req bit is set, grant the first set bit searching from the rr pointer upward with wrap (3→0). Latch grant id, we, addr, wdata. Go to ACCESS with counter=RD_LAT-1.
  - ACCESS: counter decrements each cycle. At counter==0:
    - write: memory written in that cycle.
    - read: memory read and data registered.
    - Go to RESP.
  - RESP: done[grant]=1 for exactly one cycle. rdata = read word (reads) or unchanged (writes). rr pointer = grant+1 mod 4. Return to IDLE.
- Latency: grant cycle → done is RD_LAT+1 cycles. Minimum back-to-back spacing is RD_LAT+2 cycles per transaction.
- busy = (state != IDLE).
- Out-of-range address (addr ≥ DEPTH):
  - write is dropped and read returns 0x0000_0000.
  - done still pulses and oob sets.
- A req that drops before grant is simply not served; no error.
- A req held past its done cycle is treated as a new request. It is re-arbitrated at the lowest rr priority, so no starvation.
- Simultaneous requests: strict round-robin; each channel is served at most once per 4 grants while others wait.
- rst asserted mid-transaction:
  - Immediate return to IDLE, done=0, busy=0.
  - An in-flight write may or may not have landed; reads are lost.
  - The initiator must reissue.
- done is one-hot or zero in every cycle.

Test Plan:
- Single write then read, channel a: write addr 0x005 data 0xDEADBEEF, then read 0x005. Required: done[0] pulses 3 cycles after each grant (RD_LAT=2); rdata=0xDEADBEEF on the read done cycle; busy high exactly 3 cycles per transaction.
- All four channels request reads at once after reset, with mem[0..3]=0x11,0x22,0x33,0x44 and channel i reading addr i. Required: done order a,b,c,d with rdata 0x11,0x22,0x33,0x44; then from rr=0 again (pointer after d wraps to a).
- Fairness: channel a holds req continuously while c requests once. Required: c is served immediately after a's first transaction; a is not granted twice in a row while c is pending.
- Out-of-range: channel b writes addr 1023 when DEPTH=1000, then reads addr 1023. Required: both done[1] pulses occur; read rdata=0; oob=1 and stays 1 until rst.
- Reset mid-operation: assert rst one cycle into ACCESS of a channel-d read. Required: done stays 0; busy=0 and oob=0 asynchronously; after release, a fresh channel-d request completes normally with correct data.
- Latency parameter: RD_LAT=1 build, channel c write then read 0x3FF ← 0x12345678 with DEPTH=1024. Required: done 2 cycles after grant; rdata=0x12345678.
